// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline writeback and a 2-entry MDU result FIFO
module wb_port_arbiter #(
    parameter int REG_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pipe_wb_valid,
    input  logic [ADDR_WIDTH-1:0]    pipe_wb_rd,
    input  logic [REG_WIDTH-1:0]     pipe_wb_data,
    output logic                     pipe_stall,
    input  logic                     mdu_valid,
    input  logic [ADDR_WIDTH-1:0]    mdu_rd,
    input  logic [REG_WIDTH-1:0]     mdu_data,
    output logic                     mdu_ready,
    output logic                     rf_we,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [REG_WIDTH-1:0]     rf_wdata,
    output logic [2**ADDR_WIDTH-1:0] pending_mask
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

    logic [ADDR_WIDTH-1:0] fifo_rd   [2];
    logic [REG_WIDTH-1:0]  fifo_data [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [3:0]            starve_cnt;

    logic                  head_valid;
    logic                  push;
    logic                  fifo_grant;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [REG_WIDTH-1:0]  head_data;

    assign head_valid = (count != 2'd0);
    assign mdu_ready  = (count != 2'd2);
    assign push       = mdu_valid & mdu_ready;
    assign fifo_grant = head_valid & (~pipe_wb_valid | (starve_cnt == STARVE_MAX));
    assign pipe_stall = pipe_wb_valid & fifo_grant;
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // An entry is live when the FIFO is full, or when it is the single entry at the head.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (((count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(i)))) &&
                (fifo_rd[i] != '0)) begin
                pending_mask[fifo_rd[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mdu_rd;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            starve_cnt <= 4'd0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_grant) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, fifo_grant})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            // Reaching this else branch implies both sources competed and the pipeline won.
            if (fifo_grant || !head_valid) begin
                starve_cnt <= 4'd0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (fifo_grant) begin
                rf_we    <= (head_rd != '0);
                rf_waddr <= head_rd;
                rf_wdata <= head_data;
            end else if (pipe_wb_valid) begin
                rf_we    <= (pipe_wb_rd != '0);
                rf_waddr <= pipe_wb_rd;
                rf_wdata <= pipe_wb_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending_mask;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [36:0] sb [$];
    logic [36:0] exp_w;

    wb_port_arbiter #(.REG_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pipe_wb_valid(pipe_wb_valid),
        .pipe_wb_rd   (pipe_wb_rd),
        .pipe_wb_data (pipe_wb_data),
        .pipe_stall   (pipe_stall),
        .mdu_valid    (mdu_valid),
        .mdu_rd       (mdu_rd),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pdata(input logic [4:0] r);
        return 32'hA000_0000 | 32'(r);
    endfunction

    function automatic logic [31:0] mdata(input logic [4:0] r);
        return 32'hB000_0000 | 32'(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // src: 0 = no write expected from this cycle's grant, 1 = pipeline write, 2 = FIFO write
    task automatic cyc(input logic pv, input logic [4:0] prd, input logic mv, input logic [4:0] mrd,
                       input logic rdy, input logic stl, input int src, input logic [4:0] erd);
        @(posedge clk);
        #1;
        pipe_wb_valid = pv;
        pipe_wb_rd    = prd;
        pipe_wb_data  = pdata(prd);
        mdu_valid     = mv;
        mdu_rd        = mrd;
        mdu_data      = mdata(mrd);
        #2;
        chk("mdu_ready", 64'(mdu_ready), 64'(rdy));
        chk("pipe_stall", 64'(pipe_stall), 64'(stl));
        if (src == 1) sb.push_back({erd, pdata(erd)});
        else if (src == 2) sb.push_back({erd, mdata(erd)});
    endtask

    always @(negedge clk) begin
        if (reset_n && rf_we) begin
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write at %0t",
                         rf_waddr, rf_wdata, $time);
            end else begin
                exp_w = sb.pop_front();
                if ({rf_waddr, rf_wdata} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h at %0t",
                             rf_waddr, rf_wdata, exp_w[36:32], exp_w[31:0], $time);
                end
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        pipe_wb_valid = 1'b0;
        pipe_wb_rd    = '0;
        pipe_wb_data  = '0;
        mdu_valid     = 1'b0;
        mdu_rd        = '0;
        mdu_data      = '0;
        #12;
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_mdu_ready", 64'(mdu_ready), 64'd1);
        chk("reset_pending", 64'(pending_mask), 64'd0);
        chk("reset_stall", 64'(pipe_stall), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // single pipeline write, one-cycle latency
        @(posedge clk);
        #1;
        pipe_wb_valid = 1'b1;
        pipe_wb_rd    = 5'd5;
        pipe_wb_data  = 32'hDEAD_BEEF;
        #2;
        chk("t1_stall", 64'(pipe_stall), 64'd0);
        chk("t1_ready", 64'(mdu_ready), 64'd1);
        sb.push_back({5'd5, 32'hDEAD_BEEF});
        @(posedge clk);
        #1 pipe_wb_valid = 1'b0;
        #2 chk("t1_rf_we", 64'(rf_we), 64'd1);

        // lone MDU result: mask set after push, cleared with its write
        cyc(0, 0, 1, 7, 1, 0, 0, 0);
        chk("t2_pending_nobypass", 64'(pending_mask), 64'd0);
        cyc(0, 0, 0, 0, 1, 0, 2, 7);
        chk("t2_pending_set", 64'(pending_mask), 64'(32'h1 << 7));
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t2_rf_we", 64'(rf_we), 64'd1);
        chk("t2_pending_clr", 64'(pending_mask), 64'd0);

        // starvation: pipeline wins 3 conflict cycles, then FIFO forced through
        cyc(1, 1, 1, 9, 1, 0, 1, 1);
        cyc(1, 2, 0, 0, 1, 0, 1, 2);
        cyc(1, 3, 0, 0, 1, 0, 1, 3);
        cyc(1, 4, 0, 0, 1, 0, 1, 4);
        cyc(1, 5, 0, 0, 1, 1, 2, 9);
        cyc(1, 5, 0, 0, 1, 0, 1, 5);
        chk("t3_pending_clr", 64'(pending_mask), 64'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // full FIFO back-pressure and ordering under a saturated port
        cyc(1, 10, 1, 20, 1, 0, 1, 10);
        cyc(1, 11, 1, 21, 1, 0, 1, 11);
        cyc(1, 12, 1, 22, 0, 0, 1, 12);
        chk("t4_pending_full", 64'(pending_mask), 64'((32'h1 << 20) | (32'h1 << 21)));
        cyc(1, 13, 1, 22, 0, 0, 1, 13);
        cyc(1, 14, 1, 22, 0, 1, 2, 20);
        cyc(1, 14, 1, 22, 1, 0, 1, 14);
        cyc(1, 15, 0, 0, 0, 0, 1, 15);
        cyc(1, 16, 0, 0, 0, 0, 1, 16);
        cyc(1, 17, 0, 0, 0, 1, 2, 21);
        cyc(1, 17, 0, 0, 1, 0, 1, 17);
        cyc(0, 0, 0, 0, 1, 0, 2, 22);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_pending_empty", 64'(pending_mask), 64'd0);

        // rd = 0 from both sources is consumed silently
        cyc(1, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t5_pending_rd0", 64'(pending_mask), 64'd0);
        chk("t5_rf_we_pipe", 64'(rf_we), 64'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t5_rf_we_fifo", 64'(rf_we), 64'd0);

        // reset with two queued entries and a write in flight
        cyc(1, 3, 1, 12, 1, 0, 1, 3);
        cyc(1, 4, 1, 13, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        pipe_wb_valid = 1'b1;
        pipe_wb_rd    = 5'd5;
        pipe_wb_data  = pdata(5'd5);
        mdu_valid     = 1'b0;
        chk("t6_pending_pre", 64'(pending_mask), 64'((32'h1 << 12) | (32'h1 << 13)));
        chk("t6_rf_we_pre", 64'(rf_we), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rf_we_rst", 64'(rf_we), 64'd0);
        chk("t6_ready_rst", 64'(mdu_ready), 64'd1);
        chk("t6_pending_rst", 64'(pending_mask), 64'd0);
        pipe_wb_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t6_pending_post", 64'(pending_mask), 64'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t6_rf_we_post", 64'(rf_we), 64'd0);

        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback stream and results from the long-latency multiply/divide unit (MDU).
- MDU results are held in a 2-entry FIFO and compete with pipeline writebacks under a bounded-starvation priority scheme.
- Drives a registered write port into the register file.
- Exports a pending-destination mask so decode can hold off RAW/WAW hazards on registers with queued MDU results.

Parameters:
- REG_WIDTH, `REG_WIDTH, data width of a register-file write.
- ADDR_WIDTH, 5, register index width.
- STARVE_LIMIT, 4, consecutive pipeline-won conflict cycles before the FIFO head is forced through (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous reset, active low.
- pipe_wb_valid  input  1  pipeline WB stage holds a register write this cycle.
- pipe_wb_rd  input  ADDR_WIDTH  pipeline destination register.
- pipe_wb_data  input  REG_WIDTH  pipeline writeback data.
- pipe_stall  output  1  pipeline write not accepted this cycle; WB stage must hold valid/rd/data stable.
- mdu_valid  input  1  MDU offers a result.
- mdu_rd  input  ADDR_WIDTH  MDU destination register.
- mdu_data  input  REG_WIDTH  MDU result.
- mdu_ready  output  1  FIFO can accept a result; transfer occurs on mdu_valid & mdu_ready.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  output  REG_WIDTH  register-file write data (registered).
- pending_mask  output  2**ADDR_WIDTH  bit i set while any FIFO entry targets register i (i != 0).

Behaviour:
- Reset (async assert, sync release): FIFO emptied (count 0, pointers 0), starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0. Combinational outputs then read mdu_ready=1, pending_mask=0, pipe_stall=0. Reset mid-operation discards queued MDU results; no write issues.
- FIFO: 2 entries {rd, data}.
  - mdu_ready = (count != 2), computed from registered state only. A full FIFO does not accept a push even if it pops in the same cycle.
  - Push and pop in the same cycle keep count unchanged. Pointers wrap modulo 2.
  - A pushed entry is visible at the head no earlier than the next cycle (no bypass).
- Arbitration, evaluated each cycle with head_valid = (count != 0):
  - Only pipe_wb_valid: grant PIPE.
  - Only head_valid: grant FIFO (pop).
  - Both, starve_cnt < STARVE_LIMIT-1: grant PIPE; starve_cnt += 1.
  - Both, starve_cnt == STARVE_LIMIT-1: grant FIFO (pop); pipe_stall=1; starve_cnt=0.
  - starve_cnt clears to 0 whenever FIFO is granted or FIFO is empty. It never exceeds STARVE_LIMIT-1.
  - pipe_stall = pipe_wb_valid & FIFO granted. This is the only stall source.
- Write port: the granted {rd, data} is registered. rf_we asserts the cycle after grant, with rf_waddr/rf_wdata valid in the same cycle.
  - Grants with rd == 0 are consumed (pop / accept) but produce rf_we=0.
  - No grant: rf_we=0; rf_waddr/rf_wdata hold their previous values.
- pending_mask: combinational OR of the one-hot decode of rd over valid FIFO entries, excluding rd=0. Derived from state only, so there is no path from mdu_* inputs.
  - A bit clears the cycle after the last entry with that rd pops, which is the same cycle rf_we for it is high.
  - Decode must stall any instruction whose rs/rd hits pending_mask. The arbiter itself does not reorder or check WAW.
- Latency: pipeline write to rf_we is 1 cycle when unstalled. MDU push to rf_we is at least 2 cycles.

Test Plan:
- Reset, then pipe_wb_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pipe_stall=0 throughout; mdu_ready=1.
- MDU pushes rd=7, data=0x11 with pipeline idle -> pending_mask bit 7 set the cycle after push; FIFO granted the following cycle; rf_we=1 with addr 7 one cycle later, same cycle bit 7 clears.
- FIFO holds 1 entry, pipe_wb_valid held high continuously, STARVE_LIMIT=4 -> pipeline granted 3 cycles; 4th cycle pipe_stall=1 and FIFO popped; the stalled pipeline write issues the next cycle; starve_cnt back to 0.
- Push 2 MDU results while the pipeline saturates the port -> mdu_ready=0 with count=2; a 3rd mdu_valid is held off; mdu_ready=1 the cycle after the first pop; FIFO order preserved on rf_waddr.
- MDU push with rd=0 and pipeline write with rd=0 -> both consumed, rf_we never asserts, pending_mask stays 0.
- Reset asserted with 2 queued entries and a pending grant -> rf_we=0 immediately; after release mdu_ready=1, pending_mask=0, and no stale write appears.
